sprite_rom_arbiter: RTL
=======================

// Module: sprite_rom_arbiter
// PURPOSE
//  Shares one synchronous sprite ROM read port (address in, palette index out) among NUM_REQ
//  requesters (background, fireboy, watergirl, UI sprites). Round-robin arbitration, one grant
//  per cycle, returns ROM data tagged to the winning requester. Requester 0 is the live pixel
//  path; while the display is active it gets strict priority over all others.
// PARAMETERS
//  NUM_REQ   4   number of requesters, 2..8
//  ADDR_W    9   ROM address width
//  DATA_W    4   ROM data (palette index) width
//  ROM_LAT   1   ROM read latency in vga_clk cycles, from rom_addr to rom_q, 1..4
// PORTS
//  vga_clk    in   1               single clock, all logic on posedge
//  reset      in   1               asynchronous, active-high
//  blank      in   1               1 = active display region, enables req 0 priority
//  req        in   NUM_REQ         per-requester read request, level
//  req_addr   in   NUM_REQ*ADDR_W  flattened addresses, slice i = requester i
//  gnt        out  NUM_REQ         one-hot grant, combinational from req/pointer/blank
//  rvalid     out  NUM_REQ         one-hot, data for requester i valid on rdata
//  rdata      out  DATA_W          registered ROM data, broadcast to all requesters
//  rom_addr   out  ADDR_W          address to ROM
//  rom_q      in   DATA_W          ROM output, valid ROM_LAT cycles after rom_addr
// BEHAVIOUR
//  Reset: rr_ptr=0, tag pipeline cleared, rvalid=0, rdata=0. rom_addr=0 whenever no grant.
//  Handshake: requester i holds req[i] and its addr until it sees gnt[i]=1 in a cycle; that
//   cycle is the transfer. Addr change while req high and ungranted is allowed (latest used).
//  Arbitration, each cycle:
//   - blank=1 and req[0]=1 -> gnt[0], rr_ptr unchanged.
//   - otherwise scan i = rr_ptr, rr_ptr+1, ... mod NUM_REQ (req 0 included); first req wins.
//   - on any round-robin grant to k: rr_ptr <= (k+1) mod NUM_REQ next cycle.
//   - no req -> gnt=0, rr_ptr holds.
//  gnt at most one-hot; rom_addr = req_addr slice of the granted requester, same cycle.
//  Tag pipeline: ROM_LAT+1 stage shift register of {valid, id}; stage 0 loaded from the
//   grant each cycle. rdata <= rom_q and rvalid <= onehot(id) at the last stage.
//   => rvalid[k] rises exactly ROM_LAT+1 cycles after the gnt[k] cycle. Throughput 1/cycle,
//   back-to-back grants give back-to-back rvalid with no bubbles.
//  rdata holds its last value when rvalid=0 (no clear). rvalid pulses one cycle per grant.
//  Starvation bound: with blank=0, any held req is granted within NUM_REQ cycles. With
//   blank=1 and req[0] continuous, others are starved by design (blank frees them).
//  Reset mid-operation: in-flight tags discarded immediately; no rvalid for pre-reset
//   grants; first post-reset grant follows rr_ptr=0 rules.
//  blank toggles mid-burst: only affects the current cycle's arbitration; in-flight reads
//   complete normally.
//  id width = clog2(NUM_REQ), min 1. No other state.
// TESTING
//  1 Reset: assert reset async mid-cycle -> gnt/rvalid/rdata 0 at once, rr_ptr=0 after release.
//  2 Single: blank=0, req=0010, addr1=9'd37, ROM model q=addr[3:0] -> gnt=0010 cycle t,
//    rom_addr=37, rvalid=0010 and rdata=4'h5 at t+ROM_LAT+1.
//  3 Round robin: req=1111 held, blank=0 -> grants 0001,0010,0100,1000,0001 consecutive.
//  4 Priority: blank=1, req=1011 held 4 cycles -> gnt=0001 all 4; drop blank -> next grant
//    to requester at rr_ptr order (1 then 3).
//  5 Pipeline: ROM_LAT=3, 8 back-to-back grants -> 8 consecutive rvalid, ids in grant order,
//    rdata matches each address.
//  6 Reset with 2 reads in flight -> no rvalid ever for them; new req after reset returns once.

Source files
------------

// File: rtl/sprite_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_rom_arbiter_if
//  Description : Requester bus and ROM port bundle for the sprite ROM arbiter.
//                The requester side (slice per requester) and the shared ROM
//                read port travel together.
//  Revision    : 1.0  initial release
// ============================================================================
interface sprite_rom_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 4
);
    logic                        blank;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ-1:0]          gnt;
    logic [NUM_REQ-1:0]          rvalid;
    logic [DATA_W-1:0]           rdata;
    logic [ADDR_W-1:0]           rom_addr;
    logic [DATA_W-1:0]           rom_q;

    // Requesters plus the ROM itself: drive requests and ROM data, observe the rest.
    modport master (
        output blank, req, req_addr, rom_q,
        input  gnt, rvalid, rdata, rom_addr
    );

    // The arbiter.
    modport slave (
        input  blank, req, req_addr, rom_q,
        output gnt, rvalid, rdata, rom_addr
    );
endinterface
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_rom_arbiter
//  Description : Shares one synchronous sprite ROM read port among NUM_REQ
//                requesters. Round-robin grant, one per cycle; requester 0
//                (live pixel path) wins outright while blank=1. Returned data
//                is tagged back to the winner via a {valid,id} pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  wire                 vga_clk,
    input  wire                 reset,
    sprite_rom_arbiter_if.slave bus
);

    localparam int              ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int              SUM_W   = ID_W + 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]  rr_ptr;
    logic             win_valid;
    logic             rr_grant;
    logic [ID_W-1:0]  win_id;
    logic [SUM_W-1:0] scan_sum;
    logic [ID_W-1:0]  scan_id;

    // Tag stages 0..ROM_LAT-1 track reads while the ROM is busy; the rvalid/rdata
    // register is the final stage, giving ROM_LAT+1 stages grant-to-rvalid.
    logic [ROM_LAT-1:0] tag_vld;
    logic [ID_W-1:0]    tag_id [ROM_LAT];

    // Pick the winner: requester 0 bypasses the rotation during active display,
    // otherwise scan from rr_ptr with wrap. Nothing is granted while in reset.
    always_comb begin
        win_valid = 1'b0;
        rr_grant  = 1'b0;
        win_id    = '0;
        scan_sum  = '0;
        scan_id   = '0;
        if (!reset) begin
            if (bus.blank && bus.req[0]) begin
                win_valid = 1'b1;
            end else begin
                for (int off = 0; off < NUM_REQ; off++) begin
                    scan_sum = {1'b0, rr_ptr} + SUM_W'(off);
                    if (scan_sum >= SUM_W'(NUM_REQ)) begin
                        scan_sum = scan_sum - SUM_W'(NUM_REQ);
                    end
                    scan_id = scan_sum[ID_W-1:0];
                    if (!win_valid && bus.req[scan_id]) begin
                        win_valid = 1'b1;
                        rr_grant  = 1'b1;
                        win_id    = scan_id;
                    end
                end
            end
        end
    end

    // One-hot grant and the winner's address straight to the ROM; zero when idle.
    always_comb begin
        bus.gnt      = '0;
        bus.rom_addr = '0;
        if (win_valid) begin
            bus.gnt[win_id] = 1'b1;
            bus.rom_addr    = bus.req_addr[int'(win_id)*ADDR_W +: ADDR_W];
        end
    end

    // Round-robin pointer moves past the winner only for rotation grants.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (rr_grant) begin
            rr_ptr <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
        end
    end

    // Tag shift register follows each read through the ROM latency.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            tag_vld <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_vld[0] <= win_valid;
            tag_id[0]  <= win_id;
            for (int s = 1; s < ROM_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    // Capture ROM data for the tag arriving now; rdata holds between reads.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            bus.rvalid <= '0;
            bus.rdata  <= '0;
        end else if (tag_vld[ROM_LAT-1]) begin
            bus.rvalid <= NUM_REQ'(1) << tag_id[ROM_LAT-1];
            bus.rdata  <= bus.rom_q;
        end else begin
            bus.rvalid <= '0;
        end
    end

endmodule
`default_nettype wire
